// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for clients of the block-RAM ports: requester ids,
// default geometry and the read-response pipeline record.
package ram_port_arbiter_pkg;

  localparam int DEFAULT_DWIDTH = 32;
  localparam int DEFAULT_AWIDTH = 9;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // One outstanding read response: the RAM has a single cycle of latency.
  typedef struct packed {
    logic valid;
    logic id;
  } rsp_t;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with burst lock. Holds the last-granted id and
// the lock owner; the grant itself is combinational from the request state.
module rr_grant2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant,
  output logic       winner
);

  logic last;
  logic lock_active;
  logic lock_owner;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant  = '0;
    winner = ID_M0;
    if (!reset) begin
      if (lock_active && valid[lock_owner]) begin
        winner = lock_owner;
      end else if (&valid) begin
        winner = other_id(last);
      end else if (valid[ID_M1]) begin
        winner = ID_M1;
      end else begin
        winner = ID_M0;
      end
      grant[winner] = valid[winner];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last        <= ID_M1;
      lock_active <= 1'b0;
      lock_owner  <= ID_M0;
    end else if (|grant) begin
      last        <= winner;
      lock_active <= lock[winner];
      lock_owner  <= winner;
    end else begin
      // An idle cycle ends any burst; the priority pointer holds.
      lock_active <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-read, read-first RAM port between two requesters,
// one access per cycle, and steers read data back to the issuing requester.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int AWIDTH = DEFAULT_AWIDTH
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_di,
  input  logic [DWIDTH-1:0] ram_do
);

  logic [1:0] grant;
  logic       winner;
  rsp_t       rsp;

  rr_grant2 u_grant (
    .clk    (clk),
    .reset  (reset),
    .valid  ({m1_valid, m0_valid}),
    .lock   ({m1_lock, m0_lock}),
    .grant  (grant),
    .winner (winner)
  );

  assign m0_ready = grant[ID_M0];
  assign m1_ready = grant[ID_M1];

  // Idle port drives zeros so the RAM pins are quiet between accesses.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (|grant) begin
      ram_en = 1'b1;
      if (winner == ID_M1) begin
        ram_we   = m1_we;
        ram_addr = m1_addr;
        ram_di   = m1_wdata;
      end else begin
        ram_we   = m0_we;
        ram_addr = m0_addr;
        ram_di   = m0_wdata;
      end
    end
  end

  // Tracks which requester owns the data the RAM presents next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp <= '0;
    end else begin
      rsp.valid <= ram_en & ~ram_we;
      rsp.id    <= winner;
    end
  end

  assign m0_rvalid = rsp.valid && (rsp.id == ID_M0);
  assign m1_rvalid = rsp.valid && (rsp.id == ID_M1);
  assign m0_rdata  = ram_do;
  assign m1_rdata  = ram_do;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-first RAM
// model on the shared port; one task per scenario.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_valid, m0_ready, m0_we, m0_lock, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_we, m1_lock, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  // Read-first RAM model; preloaded with A000_0000 + address on the first edge.
  logic [DW-1:0] mem [2**AW];
  logic          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 32'hA000_0000 + DW'(i);
      loaded <= 1'b1;
    end else if (ram_en) begin
      ram_do <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_di;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic lk);
    m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic lk);
    m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, '0, '0, 1'b0);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    drive0(1'b1, 1'b1, 9'd3, 32'h55, 1'b0);
    cyc(); cyc();
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready, ram_en, ram_we, m0_rvalid, m1_rvalid} !== 6'b0)
      $display("FAIL reset_outputs: got %b exp 000000",
               {m0_ready, m1_ready, ram_en, ram_we, m0_rvalid, m1_rvalid});
    else pass_cnt++;
    cyc();
    reset = 1'b0;
    idle_all();
    settle();
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) begin
        drive0(1'b1, 1'b0, 9'd20, '0, 1'b0);
        drive1(1'b1, 1'b0, 9'd30, '0, 1'b0);
      end else begin
        idle_all();
      end
      settle();
      exp_g = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      total_cnt++;
      if ({m1_ready, m0_ready} !== exp_g)
        $display("FAIL rr_grant[%0d]: got %b exp %b", i, {m1_ready, m0_ready}, exp_g);
      else pass_cnt++;
      if (i > 0) begin
        exp_rv = (i % 2 == 1) ? 2'b01 : 2'b10;
        exp_rd = (i % 2 == 1) ? 32'hA000_0014 : 32'hA000_001E;
        total_cnt++;
        if ({m1_rvalid, m0_rvalid} !== exp_rv || ram_do !== exp_rd)
          $display("FAIL rr_rsp[%0d]: got rv=%b rd=%h exp rv=%b rd=%h",
                   i, {m1_rvalid, m0_rvalid}, ram_do, exp_rv, exp_rd);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_single_requester();
    cyc();
    drive0(1'b1, 1'b1, 9'd5, 32'hDEAD_BEEF, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready, ram_en, ram_we} !== 4'b1011 || ram_addr !== 9'd5 ||
        ram_di !== 32'hDEAD_BEEF)
      $display("FAIL single_write: got rdy/en/we=%b addr=%0d di=%h exp 1011 5 deadbeef",
               {m0_ready, m1_ready, ram_en, ram_we}, ram_addr, ram_di);
    else pass_cnt++;
    cyc();
    drive0(1'b1, 1'b0, 9'd5, '0, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, ram_en, ram_we, m0_rvalid, m1_rvalid} !== 5'b11000)
      $display("FAIL single_read: got %b exp 11000",
               {m0_ready, ram_en, ram_we, m0_rvalid, m1_rvalid});
    else pass_cnt++;
    cyc();
    idle_all();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF)
      $display("FAIL single_rsp: got rv0=%b rv1=%b rd=%h exp 1 0 deadbeef",
               m0_rvalid, m1_rvalid, m0_rdata);
    else pass_cnt++;
    cyc();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b0)
      $display("FAIL single_rsp_once: got %b exp 0", m0_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    // Priority points at m1 here, so m1 takes the first cycle and then holds it.
    for (int k = 0; k < 4; k++) begin
      cyc();
      drive0(1'b1, 1'b0, 9'd40, '0, 1'b0);
      drive1(1'b1, 1'b1, 9'(50 + k), 32'h100 + DW'(k), (k < 3));
      settle();
      total_cnt++;
      if ({m0_ready, m1_ready} !== 2'b01 || ram_addr !== 9'(50 + k))
        $display("FAIL lock_hold[%0d]: got rdy=%b addr=%0d exp 01 %0d",
                 k, {m0_ready, m1_ready}, ram_addr, 50 + k);
      else pass_cnt++;
    end
    cyc();
    drive1(1'b1, 1'b1, 9'd60, 32'h200, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready} !== 2'b10 || ram_addr !== 9'd40)
      $display("FAIL lock_release: got rdy=%b addr=%0d exp 10 40",
               {m0_ready, m1_ready}, ram_addr);
    else pass_cnt++;
    cyc();
    idle_all();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0028)
      $display("FAIL lock_rsp: got rv=%b rd=%h exp 1 a0000028", m0_rvalid, m0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_same_addr();
    cyc();
    drive0(1'b1, 1'b0, 9'd7, '0, 1'b0);
    drive1(1'b1, 1'b1, 9'd7, 32'h1234, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready, ram_we} !== 3'b011 || ram_di !== 32'h1234)
      $display("FAIL same_addr_write: got %b di=%h exp 011 1234",
               {m0_ready, m1_ready, ram_we}, ram_di);
    else pass_cnt++;
    cyc();
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready, ram_we} !== 3'b100 || ram_addr !== 9'd7)
      $display("FAIL same_addr_read: got %b addr=%0d exp 100 7",
               {m0_ready, m1_ready, ram_we}, ram_addr);
    else pass_cnt++;
    cyc();
    idle_all();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h1234)
      $display("FAIL same_addr_rsp: got rv=%b%b rd=%h exp 10 1234",
               m0_rvalid, m1_rvalid, m0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    cyc();
    drive0(1'b1, 1'b0, 9'd9, '0, 1'b0);
    settle();
    total_cnt++;
    if (m0_ready !== 1'b1)
      $display("FAIL rst_mid_accept: got %b exp 1", m0_ready);
    else pass_cnt++;
    cyc();
    reset = 1'b1;
    idle_all();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b0 || ram_en !== 1'b0)
      $display("FAIL rst_mid_discard: got rv=%b en=%b exp 0 0", m0_rvalid, ram_en);
    else pass_cnt++;
    cyc();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 9'd12, '0, 1'b0);
    drive1(1'b1, 1'b0, 9'd13, '0, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready, m0_rvalid} !== 3'b100)
      $display("FAIL rst_mid_prio: got %b exp 100", {m0_ready, m1_ready, m0_rvalid});
    else pass_cnt++;
    cyc();
    idle_all();
    settle();
    total_cnt++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_000C)
      $display("FAIL rst_mid_rsp: got rv=%b rd=%h exp 1 a000000c", m0_rvalid, m0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      cyc();
      settle();
      total_cnt++;
      if ({ram_en, ram_we, m0_ready, m1_ready, m0_rvalid, m1_rvalid} !== 6'b0 ||
          ram_addr !== '0 || ram_di !== '0)
        $display("FAIL idle[%0d]: got %b addr=%0d di=%h exp 000000 0 0", i,
                 {ram_en, ram_we, m0_ready, m1_ready, m0_rvalid, m1_rvalid}, ram_addr, ram_di);
      else pass_cnt++;
    end
    // m0 was granted last before the idle stretch, so m1 wins the next contest.
    cyc();
    drive0(1'b1, 1'b0, 9'd1, '0, 1'b0);
    drive1(1'b1, 1'b0, 9'd2, '0, 1'b0);
    settle();
    total_cnt++;
    if ({m0_ready, m1_ready} !== 2'b01)
      $display("FAIL idle_last_holds: got %b exp 01", {m0_ready, m1_ready});
    else pass_cnt++;
    cyc();
    idle_all();
    settle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_requester();
    test_lock();
    test_same_addr();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of a single-clock true-dual-port block RAM between two requesters. The shared port has 1-cycle registered read latency and read-first behaviour. The arbiter sits between two processing-core clients (e.g. stream line writer and AXI-lite config/readback) and the RAM's port pins. It issues at most one access per cycle and returns read data to the requester that issued it.

## Interface
- DWIDTH, 32, data width; must match RAM
- AWIDTH, 9, address width; must match RAM
- clk  in  1  single clock for arbiter and RAM port
- reset  in  1  asynchronous, active-high reset
- mN_valid  in  1  request valid, N∈{0,1}
- mN_ready  out  1  request accepted this cycle (grant)
- mN_we  in  1  1=write, 0=read
- mN_addr  in  AWIDTH  request address
- mN_wdata  in  DWIDTH  write data
- mN_lock  in  1  hold grant on the next cycle (burst)
- mN_rvalid  out  1  read data valid for requester N
- mN_rdata  out  DWIDTH  read data (equals ram_do)
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM port write enable
- ram_addr  out  AWIDTH  RAM port address
- ram_di  out  DWIDTH  RAM port write data
- ram_do  in  DWIDTH  RAM port registered read data

## Operation
- Accept condition: mN_valid & mN_ready.
- mN_ready is combinational from valid, priority and lock state. It never depends on mN_ready of the other port. At most one ready is high per cycle.
- Priority register `last` is the id last granted; reset value 1, so m0 wins first. With both valid and no lock, the grant goes to !last.
- Lock: if the granted requester had mN_lock=1 at acceptance, it owns the next cycle when mN_valid is high again, regardless of the other requester. Lock releases when the owner presents valid=0 or accepts with lock=0. The owner's valid=0 releases immediately and the other requester can be granted that cycle.
- RAM drive (combinational from the winning request):
  - ram_en = any accept.
  - ram_we = winner we.
  - ram_addr / ram_di = winner addr / wdata.
  - When idle: ram_en=0, ram_we=0, addr/di = 0.
- Response:
  - A read accepted in cycle T sets mN_rvalid=1 for exactly cycle T+1. mN_rdata=ram_do in that cycle.
  - Writes produce no rvalid.
  - m0_rdata and m1_rdata are both wired to ram_do; only rvalid qualifies them.
- Ordering: accesses hit the RAM in grant order. A read granted the cycle after a write to the same address returns the new data. The other RAM port is outside this block; cross-port collisions are the system's responsibility.
- No response backpressure; requesters must sink rvalid.

## Timing
- Reset values:
  - mN_rvalid=0, last=1, lock owner = none.
  - ram_en=0 and ram_we=0 while reset is asserted (outputs gated).
- Request-to-RAM latency 0 (same cycle as accept). Read-to-rvalid latency 1.
- Throughput: one access per cycle. A requester alone gets every cycle.
- Reset asserted mid-operation: an in-flight read's rvalid is discarded (not asserted after reset). Lock and priority return to reset state.
- Both requesters idle: `last` holds.

## Structure
- Shared include: requester id localparams (ID_M0=0, ID_M1=1) and the default DWIDTH/AWIDTH, reused by other RAM clients.
- Natural sub-module: rr_grant2. It is the combinational 2-way round-robin/lock grant plus the `last` and lock-owner registers.
- The top level holds the RAM mux and the rvalid pipeline register (valid bit + id).
- The RAM itself is instantiated by the parent, not inside this block.

## Test plan
- m0 alone: write 0xDEADBEEF @5 (accept cycle 0), read @5 (cycle 1) → m0_rvalid only in cycle 2, m0_rdata=0xDEADBEEF, m1_rvalid stays 0.
- Both valid continuously, lock=0, reads → grants m0,m1,m0,m1 starting at m0 after reset; each rvalid lands on the matching port one cycle after its grant.
- m1 holds lock for 4 writes while m0 valid → m1_ready 4 consecutive cycles, m0_ready=0 throughout, m0 granted in cycle 5.
- m1 writes 0x1234 @7 while m0 reads @7 in the same cycle, m1 prioritized → m1 write first, m0 read next cycle returns 0x1234.
- Reset asserted the cycle after an m0 read accept → no m0_rvalid. After release, the first contended grant goes to m0.
- No valid for 10 cycles → ram_en=0, ram_we=0, both ready=0, no rvalid.
